// File: rtl/snn_pkg.sv
// Shared constants and state encoding for the spiking-neuron datapath.
package snn_pkg;

   localparam int SNN_ADR_W  = 6;
   localparam int SNN_INPUTS = 64;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN,
      FIN
   } seq_state_t;

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-set-bit priority encoder: index 0 wins, bit INPUTS-1 is found last.
module lsb_prio_enc #(
   parameter int INPUTS = 64,
   parameter int ADR_W  = 6
) (
   input  logic [INPUTS-1:0] in_i,
   output logic [ADR_W-1:0]  idx_o,
   output logic              any_o
);

   // Descending sweep so the lowest set bit is the last assignment to stick.
   always_comb begin
      idx_o = '0;
      for (int i = INPUTS - 1; i >= 0; i--) begin
         if (in_i[i]) idx_o = ADR_W'(i);
      end
   end

   assign any_o = |in_i;

endmodule

// File: rtl/spike_fetch_sequencer.sv
// Latches a time-step spike vector and issues one weight-RAM address plus EN per active input.
module spike_fetch_sequencer
   import snn_pkg::*;
#(
   parameter int ADR_W  = SNN_ADR_W,
   parameter int INPUTS = SNN_INPUTS,
   parameter int CNT_W  = ADR_W + 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              START,
   input  logic [INPUTS-1:0] SPIKE_VEC,
   output logic [ADR_W-1:0]  DPRA,
   output logic              EN,
   output logic              ACC_CLR,
   output logic              BUSY,
   output logic              DONE,
   output logic [CNT_W-1:0]  COUNT
);

   seq_state_t        state_q, state_d;
   logic [INPUTS-1:0] mask_q, mask_d;
   logic [ADR_W-1:0]  dpra_q, dpra_d;
   logic              en_q, en_d;
   logic              clr_q, clr_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic [ADR_W-1:0]  lsb_idx;
   logic              lsb_any;

   lsb_prio_enc #(
      .INPUTS (INPUTS),
      .ADR_W  (ADR_W)
   ) u_enc (
      .in_i  (mask_q),
      .idx_o (lsb_idx),
      .any_o (lsb_any)
   );

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      dpra_d  = dpra_q;
      en_d    = 1'b0;
      clr_d   = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      count_d = count_q;
      case (state_q)
         IDLE, FIN: begin
            if (START) begin
               state_d = LOAD;
               mask_d  = SPIKE_VEC;
               count_d = '0;
               clr_d   = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         // An empty mask on entry or after the last issued address ends the step.
         LOAD, SCAN: begin
            if (lsb_any) begin
               state_d = SCAN;
               dpra_d  = lsb_idx;
               en_d    = 1'b1;
               mask_d  = mask_q & (mask_q - INPUTS'(1));
               count_d = count_q + CNT_W'(1);
            end else begin
               state_d = FIN;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q <= IDLE;
         mask_q  <= '0;
         dpra_q  <= '0;
         en_q    <= 1'b0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         dpra_q  <= dpra_d;
         en_q    <= en_d;
         clr_q   <= clr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         count_q <= count_d;
      end
   end

   assign DPRA    = dpra_q;
   assign EN      = en_q;
   assign ACC_CLR = clr_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign COUNT   = count_q;

endmodule

// File: tb/tb_spike_fetch_sequencer.sv
// Scoreboard bench for spike_fetch_sequencer: expected address/timing pushed at START, checked on output.
module tb_spike_fetch_sequencer;

   localparam int ADR_W  = 6;
   localparam int INPUTS = 64;
   localparam int CNT_W  = ADR_W + 1;

   logic              CLK = 1'b0;
   logic              RST;
   logic              START;
   logic [INPUTS-1:0] SPIKE_VEC;
   logic [ADR_W-1:0]  DPRA;
   logic              EN;
   logic              ACC_CLR;
   logic              BUSY;
   logic              DONE;
   logic [CNT_W-1:0]  COUNT;

   spike_fetch_sequencer #(
      .ADR_W  (ADR_W),
      .INPUTS (INPUTS),
      .CNT_W  (CNT_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .START     (START),
      .SPIKE_VEC (SPIKE_VEC),
      .DPRA      (DPRA),
      .EN        (EN),
      .ACC_CLR   (ACC_CLR),
      .BUSY      (BUSY),
      .DONE      (DONE),
      .COUNT     (COUNT)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   int exp_addr[$];
   int exp_clr_cyc  = -1;
   int exp_en_next  = -1;
   int exp_done_cyc = -1;
   int exp_count    = 0;
   int last_t0      = 0;
   int clr_seen     = 0;
   int done_seen    = 0;
   int ds_start     = 0;
   int cs_start     = 0;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   always @(posedge CLK) cyc <= cyc + 1;

   // Output monitor: every observed event is matched against the scoreboard.
   always @(negedge CLK) begin
      if (ACC_CLR) begin
         clr_seen++;
         chk("clr_cyc", cyc, exp_clr_cyc);
         chk("clr_busy", BUSY, 1);
         chk("clr_en_excl", EN, 0);
      end
      if (EN) begin
         chk("en_cyc", cyc, exp_en_next);
         exp_en_next++;
         if (exp_addr.size() == 0) chk("en_extra", 1, 0);
         else chk("dpra", DPRA, exp_addr.pop_front());
         chk("en_busy", BUSY, 1);
         chk("en_done_excl", DONE, 0);
      end
      if (DONE) begin
         done_seen++;
         chk("done_cyc", cyc, exp_done_cyc);
         chk("done_count", COUNT, exp_count);
         chk("addr_left", exp_addr.size(), 0);
         chk("done_busy", BUSY, 0);
      end
   end

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge CLK);
   endtask

   // Called at a falling edge; START is sampled on the next rising edge (edge 0).
   task automatic start_now(input logic [INPUTS-1:0] vec);
      int n;
      #1;
      last_t0 = cyc;
      exp_addr.delete();
      n = 0;
      for (int i = 0; i < INPUTS; i++) begin
         if (vec[i]) begin
            exp_addr.push_back(i);
            n++;
         end
      end
      exp_clr_cyc  = last_t0 + 1;
      exp_en_next  = last_t0 + 2;
      exp_done_cyc = last_t0 + n + 2;
      exp_count    = n;
      ds_start     = done_seen;
      cs_start     = clr_seen;
      START     = 1'b1;
      SPIKE_VEC = vec;
      @(posedge CLK);
      #1;
      START = 1'b0;
   endtask

   task automatic start_step(input logic [INPUTS-1:0] vec);
      @(negedge CLK);
      start_now(vec);
   endtask

   task automatic finish_step(input string tag);
      wait_cyc(exp_done_cyc + 1);
      chk({tag, "_done_once"}, done_seen - ds_start, 1);
      chk({tag, "_clr_once"}, clr_seen - cs_start, 1);
      chk({tag, "_count_hold"}, COUNT, exp_count);
      chk({tag, "_idle_busy"}, BUSY, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      RST       = 1'b0;
      START     = 1'b0;
      SPIKE_VEC = '0;
      repeat (3) @(negedge CLK);
      chk("rst_dpra", DPRA, 0);
      chk("rst_en", EN, 0);
      chk("rst_clr", ACC_CLR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_count", COUNT, 0);
      #1 RST = 1'b1;
      repeat (2) @(negedge CLK);

      start_step(64'h5);
      finish_step("two_bits");

      start_step(64'h0);
      finish_step("empty");

      start_step({INPUTS{1'b1}});
      finish_step("all_ones");

      start_step(64'h8000_0000_0000_0000);
      finish_step("top_bit");

      start_step(64'h0000_0000_8001_0090);
      chk("s5_after", 1, 1);
      wait_cyc(last_t0 + 3);
      #1;
      START     = 1'b1;
      SPIKE_VEC = 64'h0000_0000_0000_FF00;
      @(posedge CLK);
      #1;
      START     = 1'b0;
      SPIKE_VEC = 64'hFFFF_0000_0000_0000;
      wait_cyc(exp_done_cyc);
      start_now(64'h0000_0000_0000_0003);
      finish_step("chained");

      start_step({INPUTS{1'b1}});
      wait_cyc(last_t0 + 5);
      #1;
      exp_addr.delete();
      exp_clr_cyc  = -1;
      exp_en_next  = -1;
      exp_done_cyc = -1;
      ds_start     = done_seen;
      RST = 1'b0;
      @(negedge CLK);
      chk("mid_rst_dpra", DPRA, 0);
      chk("mid_rst_en", EN, 0);
      chk("mid_rst_clr", ACC_CLR, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_done", DONE, 0);
      chk("mid_rst_count", COUNT, 0);
      #1 RST = 1'b1;
      repeat (6) @(negedge CLK);
      chk("mid_rst_no_done", done_seen - ds_start, 0);

      start_step(64'h0000_1000_0000_0042);
      finish_step("post_rst");

      repeat (2) @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
